// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller and the future CPU bus arbiter:
// transfer state encoding, ROM/RAM select default and wait-counter width.
package mem_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RECOVER = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int ROM_BIT_DEFAULT = 15;
  localparam int WAIT_CNT_W      = 4;

  // Byte address of the upper half of a little-endian word; wraps at 0xFFFF.
  function automatic logic [15:0] next_byte_addr(input logic [15:0] addr);
    return addr + 16'd1;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Requester-side handshake plus the byte-wide asynchronous memory port.
// The master side models both the requesting CPU and the memory device.
interface mem_bus_ctrl_if;
  logic        req;
  logic        wr;
  logic        word;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic        err;
  logic        busy;
  logic [15:0] rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic        mem_we_bar;
  logic        mem_oe_bar;
  logic [7:0]  mem_data_in;

  modport slave (
    input  req, wr, word, addr, wdata, mem_data_in,
    output ack, err, busy, rdata, mem_addr, mem_data_out, mem_we_bar, mem_oe_bar
  );

  modport master (
    output req, wr, word, addr, wdata, mem_data_in,
    input  ack, err, busy, rdata, mem_addr, mem_data_out, mem_we_bar, mem_oe_bar
  );
endinterface

// File: rtl/mem_bus_ctrl_wait.sv
// Strobe-length down-counter: loads the wait-state count, decrements to zero and holds.
module mem_wait_counter
  import mem_bus_ctrl_pkg::*;
#(
  parameter int CNT_W = WAIT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Byte/word transfer sequencer for an asynchronous byte-wide memory with a
// write-protected ROM region; every output comes straight from a register.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ROM_BIT     = ROM_BIT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  mem_bus_ctrl_if.slave  bus
);

  localparam logic [WAIT_CNT_W-1:0] WS_LOAD = WAIT_CNT_W'(WAIT_STATES);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic        word_q, word_d;
  logic        hi_q, hi_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rd_buf_q, rd_buf_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_do_q, mem_do_d;
  logic        we_bar_q, we_bar_d;
  logic        oe_bar_q, oe_bar_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        cnt_load, cnt_dec, cnt_zero;

  mem_wait_counter #(.CNT_W(WAIT_CNT_W)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (WS_LOAD),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    word_d     = word_q;
    hi_d       = hi_q;
    wdata_d    = wdata_q;
    rd_buf_d   = rd_buf_q;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_do_d   = mem_do_q;
    we_bar_d   = we_bar_q;
    oe_bar_d   = oe_bar_q;
    ack_d      = 1'b0;
    err_d      = err_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d    = ST_SETUP;
          wr_d       = bus.wr;
          word_d     = bus.word;
          wdata_d    = bus.wdata;
          mem_addr_d = bus.addr;
          mem_do_d   = bus.wdata[7:0];
          hi_d       = 1'b0;
          err_d      = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d  = ST_STROBE;
        cnt_load = 1'b1;
        // A ROM-bound write keeps the full byte timing but never pulses WE.
        if (wr_q) begin
          if (mem_addr_q[ROM_BIT]) we_bar_d = 1'b0;
          else                     err_d    = 1'b1;
        end else begin
          oe_bar_d = 1'b0;
        end
      end
      ST_STROBE: begin
        if (cnt_zero) begin
          state_d  = ST_RECOVER;
          we_bar_d = 1'b1;
          oe_bar_d = 1'b1;
          if (!wr_q) begin
            if (hi_q) rd_buf_d[15:8] = bus.mem_data_in;
            else      rd_buf_d[7:0]  = bus.mem_data_in;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (word_q && !hi_q) begin
          state_d    = ST_SETUP;
          hi_d       = 1'b1;
          mem_addr_d = next_byte_addr(mem_addr_q);
          mem_do_d   = wdata_q[15:8];
        end else begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          // RDATA only changes when a read completes, never mid-transfer.
          if (!wr_q) rdata_d = word_q ? rd_buf_q : {8'h00, rd_buf_q[7:0]};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      word_q     <= 1'b0;
      hi_q       <= 1'b0;
      wdata_q    <= '0;
      rd_buf_q   <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_do_q   <= '0;
      we_bar_q   <= 1'b1;
      oe_bar_q   <= 1'b1;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      word_q     <= word_d;
      hi_q       <= hi_d;
      wdata_q    <= wdata_d;
      rd_buf_q   <= rd_buf_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_do_q   <= mem_do_d;
      we_bar_q   <= we_bar_d;
      oe_bar_q   <= oe_bar_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.err          = err_q;
  assign bus.busy         = busy_q;
  assign bus.rdata        = rdata_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_out = mem_do_q;
  assign bus.mem_we_bar   = we_bar_q;
  assign bus.mem_oe_bar   = oe_bar_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one DUT with one wait state, one with none,
// sharing a behavioural byte memory.
module tb_mem_bus_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_bus_ctrl_if bus1();
  mem_bus_ctrl_if bus0();

  mem_bus_ctrl #(.WAIT_STATES(1), .ROM_BIT(15)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_bus_ctrl #(.WAIT_STATES(0), .ROM_BIT(15)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // Byte memory: preload port for the bench, write port for dut1.
  logic [7:0]  mem [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus1.mem_we_bar === 1'b0) mem[bus1.mem_addr] <= bus1.mem_data_out;
  end

  assign bus1.mem_data_in = (bus1.mem_oe_bar === 1'b0) ? mem[bus1.mem_addr] : 8'hzz;
  assign bus0.mem_data_in = (bus0.mem_oe_bar === 1'b0) ? mem[bus0.mem_addr] : 8'hzz;

  int          we_cnt;
  int          oe_cnt;
  int          both_low;
  int          ack1_cnt;
  logic [15:0] last_oe_addr;

  initial begin
    we_cnt = 0; oe_cnt = 0; both_low = 0; ack1_cnt = 0; last_oe_addr = '0;
  end

  always @(negedge clk) begin
    if (bus1.mem_we_bar === 1'b0) we_cnt++;
    if (bus1.mem_oe_bar === 1'b0) begin
      oe_cnt++;
      last_oe_addr = bus1.mem_addr;
    end
    if (bus1.mem_we_bar === 1'b0 && bus1.mem_oe_bar === 1'b0) both_low++;
    if (bus0.mem_we_bar === 1'b0 && bus0.mem_oe_bar === 1'b0) both_low++;
    if (bus1.ack === 1'b1) ack1_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  // Issue one transfer on bus1 from IDLE; lat = rising edges from REQ drive to ACK (0 = none).
  task automatic run1(input logic wr, input logic word, input logic [15:0] a,
                      input logic [15:0] wd, output int lat, output logic err_at_ack);
    bus1.wr    = wr;
    bus1.word  = word;
    bus1.addr  = a;
    bus1.wdata = wd;
    bus1.req   = 1'b1;
    lat        = 0;
    err_at_ack = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      bus1.req = 1'b0;
      if (bus1.ack === 1'b1) begin
        lat        = i;
        err_at_ack = bus1.err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus1.mem_we_bar !== 1'b1) begin failures++; $display("FAIL rst_we_bar got=%b exp=1", bus1.mem_we_bar); end
    checks++; if (bus1.mem_oe_bar !== 1'b1) begin failures++; $display("FAIL rst_oe_bar got=%b exp=1", bus1.mem_oe_bar); end
    checks++; if (bus1.mem_addr !== 16'h0000) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0000", bus1.mem_addr); end
    checks++; if (bus1.mem_data_out !== 8'h00) begin failures++; $display("FAIL rst_mem_data_out got=%h exp=00", bus1.mem_data_out); end
    checks++; if (bus1.rdata !== 16'h0000) begin failures++; $display("FAIL rst_rdata got=%h exp=0000", bus1.rdata); end
    checks++; if (bus1.ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", bus1.ack); end
    checks++; if (bus1.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus1.err); end
    checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus1.busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus1.busy); end
  endtask

  task automatic test_byte_read();
    int lat; logic e; int we0; int oe0;
    preload(16'h8010, 8'hA5);
    we0 = we_cnt; oe0 = oe_cnt;
    run1(1'b0, 1'b0, 16'h8010, 16'h0000, lat, e);
    checks++; if (lat !== 5) begin failures++; $display("FAIL brd_latency got=%0d exp=5", lat); end
    checks++; if (oe_cnt - oe0 !== 2) begin failures++; $display("FAIL brd_oe_cycles got=%0d exp=2", oe_cnt - oe0); end
    checks++; if (we_cnt - we0 !== 0) begin failures++; $display("FAIL brd_we_cycles got=%0d exp=0", we_cnt - we0); end
    checks++; if (bus1.rdata !== 16'h00A5) begin failures++; $display("FAIL brd_rdata got=%h exp=00a5", bus1.rdata); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL brd_err got=%b exp=0", e); end
    checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL brd_busy_after got=%b exp=0", bus1.busy); end
  endtask

  task automatic test_word_rw();
    int lat; logic e; int we0; int oe0;
    we0 = we_cnt;
    run1(1'b1, 1'b1, 16'h8000, 16'h1234, lat, e);
    checks++; if (lat !== 9) begin failures++; $display("FAIL wwr_latency got=%0d exp=9", lat); end
    checks++; if (we_cnt - we0 !== 4) begin failures++; $display("FAIL wwr_we_cycles got=%0d exp=4", we_cnt - we0); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL wwr_err got=%b exp=0", e); end
    checks++; if (mem[16'h8000] !== 8'h34) begin failures++; $display("FAIL wwr_mem8000 got=%h exp=34", mem[16'h8000]); end
    checks++; if (mem[16'h8001] !== 8'h12) begin failures++; $display("FAIL wwr_mem8001 got=%h exp=12", mem[16'h8001]); end
    oe0 = oe_cnt;
    run1(1'b0, 1'b1, 16'h8000, 16'h0000, lat, e);
    checks++; if (lat !== 9) begin failures++; $display("FAIL wrd_latency got=%0d exp=9", lat); end
    checks++; if (oe_cnt - oe0 !== 4) begin failures++; $display("FAIL wrd_oe_cycles got=%0d exp=4", oe_cnt - oe0); end
    checks++; if (bus1.rdata !== 16'h1234) begin failures++; $display("FAIL wrd_rdata got=%h exp=1234", bus1.rdata); end
    run1(1'b0, 1'b0, 16'h8010, 16'h0000, lat, e);
    checks++; if (bus1.rdata !== 16'h00A5) begin failures++; $display("FAIL brd_hi_clear got=%h exp=00a5", bus1.rdata); end
  endtask

  task automatic test_rom_write();
    int lat; logic e; int we0;
    preload(16'h0100, 8'h77);
    we0 = we_cnt;
    run1(1'b1, 1'b0, 16'h0100, 16'h0055, lat, e);
    checks++; if (lat !== 5) begin failures++; $display("FAIL rom_latency got=%0d exp=5", lat); end
    checks++; if (we_cnt - we0 !== 0) begin failures++; $display("FAIL rom_we_cycles got=%0d exp=0", we_cnt - we0); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL rom_err got=%b exp=1", e); end
    checks++; if (mem[16'h0100] !== 8'h77) begin failures++; $display("FAIL rom_unchanged got=%h exp=77", mem[16'h0100]); end
    run1(1'b0, 1'b0, 16'h8010, 16'h0000, lat, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", e); end
  endtask

  task automatic test_straddle();
    int lat; logic e; int we0;
    preload(16'h7FFF, 8'h11);
    preload(16'h8000, 8'h00);
    we0 = we_cnt;
    run1(1'b1, 1'b1, 16'h7FFF, 16'hBEEF, lat, e);
    checks++; if (lat !== 9) begin failures++; $display("FAIL strad_latency got=%0d exp=9", lat); end
    checks++; if (we_cnt - we0 !== 2) begin failures++; $display("FAIL strad_we_cycles got=%0d exp=2", we_cnt - we0); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL strad_err got=%b exp=1", e); end
    checks++; if (mem[16'h8000] !== 8'hBE) begin failures++; $display("FAIL strad_mem8000 got=%h exp=be", mem[16'h8000]); end
    checks++; if (mem[16'h7FFF] !== 8'h11) begin failures++; $display("FAIL strad_mem7fff got=%h exp=11", mem[16'h7FFF]); end
    preload(16'hFFFF, 8'h3C);
    preload(16'h0000, 8'hC3);
    run1(1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, e);
    checks++; if (lat !== 9) begin failures++; $display("FAIL wrap_latency got=%0d exp=9", lat); end
    checks++; if (last_oe_addr !== 16'h0000) begin failures++; $display("FAIL wrap_addr got=%h exp=0000", last_oe_addr); end
    checks++; if (bus1.rdata !== 16'hC33C) begin failures++; $display("FAIL wrap_rdata got=%h exp=c33c", bus1.rdata); end
  endtask

  task automatic test_reset_mid();
    int lat; logic e; int a0; logic seen;
    a0 = ack1_cnt;
    seen = 1'b0;
    bus1.wr = 1'b1; bus1.word = 1'b0; bus1.addr = 16'h8020; bus1.wdata = 16'h0066;
    bus1.req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus1.req = 1'b0;
      if (bus1.mem_we_bar === 1'b0) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL mid_strobe_seen got=%b exp=1", seen); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus1.mem_we_bar !== 1'b1) begin failures++; $display("FAIL mid_we_release got=%b exp=1", bus1.mem_we_bar); end
    checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", bus1.busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (ack1_cnt - a0 !== 0) begin failures++; $display("FAIL mid_no_ack got=%0d exp=0", ack1_cnt - a0); end
    run1(1'b0, 1'b0, 16'h8010, 16'h0000, lat, e);
    checks++; if (lat !== 5) begin failures++; $display("FAIL mid_next_latency got=%0d exp=5", lat); end
    checks++; if (bus1.rdata !== 16'h00A5) begin failures++; $display("FAIL mid_next_rdata got=%h exp=00a5", bus1.rdata); end
  endtask

  task automatic test_back_to_back();
    int n; int first; int prev; int badper;
    n = 0; first = 0; prev = 0; badper = 0;
    bus0.wr = 1'b0; bus0.word = 1'b0; bus0.addr = 16'h8010; bus0.wdata = 16'h0000;
    bus0.req = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      @(posedge clk); #1;
      if (bus0.ack === 1'b1) begin
        n++;
        if (n == 1) first = i;
        else if (i - prev != 5) badper++;
        prev = i;
      end
    end
    bus0.req = 1'b0;
    checks++; if (first !== 4) begin failures++; $display("FAIL b2b_first_ack got=%0d exp=4", first); end
    checks++; if (n !== 5) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=5", n); end
    checks++; if (badper !== 0) begin failures++; $display("FAIL b2b_period_errors got=%0d exp=0", badper); end
    checks++; if (bus0.rdata !== 16'h00A5) begin failures++; $display("FAIL b2b_rdata got=%h exp=00a5", bus0.rdata); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", bus0.busy); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus1.req = 1'b0; bus1.wr = 1'b0; bus1.word = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    bus0.req = 1'b0; bus0.wr = 1'b0; bus0.word = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    test_reset();
    test_byte_read();
    test_word_rw();
    test_rom_write();
    test_straddle();
    test_reset_mid();
    test_back_to_back();
    checks++; if (both_low !== 0) begin failures++; $display("FAIL strobes_both_low got=%0d exp=0", both_low); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
